// File: rtl/uart_tx_param.sv
// Parametrised RS-232 transmitter: a small input FIFO feeds a frame serialiser
// (start, DATA_BITS LSB-first, optional parity, STOP_BITS stop) paced by a baud counter.
module uart_tx_param #(
  parameter int CLK_DIV    = 560,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          xmit_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    fsm_state
);

  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_param: unsupported parameter set");
  end

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLK_DIV - 1);
  localparam logic [3:0]        DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic              STOP_LAST  = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2:0]           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 xmit_q, xmit_d;

  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head;
  logic                 head_parity;

  // Handshake: a word transfers on a rising clk edge where tx_valid and tx_ready
  // are both high; tx_ready depends only on FIFO occupancy, never on tx_valid.
  assign tx_ready    = (count_q != FULL_COUNT);
  assign push        = tx_valid & tx_ready;
  assign head        = mem_q[rd_ptr_q];
  assign head_parity = (PARITY == 1) ? ~(^head) : (^head);
  assign bit_end     = (baud_q == BAUD_LAST);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    pop        = 1'b0;
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          shift_d  = head;
          parity_d = head_parity;
          baud_d   = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == DATA_LAST) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          stop_idx_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            // Chain straight into the next frame so queued words go out gap-free.
            if (count_q != '0) begin
              pop      = 1'b1;
              shift_d  = head;
              parity_d = head_parity;
              baud_d   = '0;
              state_d  = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line is registered from the next-state view so it changes exactly at the
  // edge where the FSM does, without a combinational path to the pin.
  always_comb begin
    xmit_d = 1'b1;
    case (state_d)
      S_START: xmit_d = 1'b0;
      S_DATA:  xmit_d = shift_d[0];
      S_PAR:   xmit_d = parity_d;
      default: xmit_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      xmit_q     <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      xmit_q     <= xmit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  assign xmit_data  = xmit_q;
  assign busy       = (state_q != S_IDLE) | (count_q != '0);
  assign fifo_count = count_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three differently configured instances checked every cycle
// against a queue-of-line-levels model, plus directed frame vectors and corner sequences.
module tb_uart_tx_param;

  localparam int N = 3;
  localparam int CDIV [N] = '{4, 4, 2};
  localparam int DW   [N] = '{8, 8, 9};
  localparam int PAR  [N] = '{0, 2, 1};
  localparam int STB  [N] = '{1, 2, 1};
  localparam int DEP  [N] = '{4, 4, 2};

  typedef struct {
    int         inst;
    logic [8:0] data;
    int         nbits;
    logic [15:0] bits;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] tx_data  [N];
  logic       tx_valid [N];
  logic       tx_ready [N];
  logic       xmit     [N];
  logic       busy     [N];
  logic [3:0] cnt      [N];

  logic [8:0] m_fifo [N][$];
  logic       m_line [N][$];
  bit         m_acc  [N];
  bit         chk_en = 1'b0;
  logic       trace  [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = $clog2(DEP[g]) + 1;
    logic [CW-1:0] fc;
    logic [2:0]    st;
    uart_tx_param #(
      .CLK_DIV(CDIV[g]), .DATA_BITS(DW[g]), .PARITY(PAR[g]),
      .STOP_BITS(STB[g]), .FIFO_DEPTH(DEP[g])
    ) u_dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .tx_data   (tx_data[g][DW[g]-1:0]),
      .tx_valid  (tx_valid[g]),
      .tx_ready  (tx_ready[g]),
      .xmit_data (xmit[g]),
      .busy      (busy[g]),
      .fifo_count(fc),
      .fsm_state (st)
    );
    assign cnt[g] = 4'(fc);
  end

  task automatic check(string name, int i, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  // Expected line levels for one frame, one entry per clk cycle.
  function automatic void append_frame(int i, logic [8:0] w);
    logic lv [$];
    logic p;
    p = 1'b0;
    lv.push_back(1'b0);
    for (int b = 0; b < DW[i]; b++) begin
      lv.push_back(w[b]);
      p ^= w[b];
    end
    if (PAR[i] != 0) lv.push_back((PAR[i] == 1) ? ~p : p);
    for (int s = 0; s < STB[i]; s++) lv.push_back(1'b1);
    foreach (lv[k]) for (int c = 0; c < CDIV[i]; c++) m_line[i].push_back(lv[k]);
  endfunction

  function automatic void model_step();
    for (int i = 0; i < N; i++) begin
      bit         do_push;
      logic [8:0] w;
      m_acc[i] = 1'b0;
      if (!rst_n) begin
        m_fifo[i].delete();
        m_line[i].delete();
      end else begin
        do_push = tx_valid[i] && (m_fifo[i].size() != DEP[i]);
        if (m_line[i].size() != 0) void'(m_line[i].pop_front());
        if (m_line[i].size() == 0 && m_fifo[i].size() != 0) begin
          w = m_fifo[i].pop_front();
          append_frame(i, w);
        end
        if (do_push) begin
          m_fifo[i].push_back(tx_data[i] & 9'((1 << DW[i]) - 1));
          m_acc[i] = 1'b1;
        end
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check("xmit", i, xmit[i], (m_line[i].size() != 0) ? m_line[i][0] : 1'b1);
        check("busy", i, busy[i], (m_line[i].size() != 0) || (m_fifo[i].size() != 0));
        check("fifo_count", i, cnt[i], m_fifo[i].size());
        check("tx_ready", i, tx_ready[i], m_fifo[i].size() != DEP[i]);
      end
    end
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic push_word(int i, logic [8:0] d);
    bit done;
    done = 1'b0;
    tx_valid[i] = 1'b1;
    tx_data[i]  = d;
    for (int t = 0; t < 400 && !done; t++) begin
      tick();
      done = m_acc[i];
    end
    tx_valid[i] = 1'b0;
    if (!done) check("push_timeout", i, 0, 1);
  endtask

  task automatic wait_idle(int i);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      if (!busy[i] && m_line[i].size() == 0 && m_fifo[i].size() == 0) done = 1'b1;
      else tick();
    end
    if (!done) check("idle_timeout", i, 0, 1);
  endtask

  task automatic capture(int i, int n);
    trace.delete();
    for (int k = 0; k < n; k++) begin
      trace.push_back(xmit[i]);
      tick();
    end
  endtask

  task automatic run_vec(vec_t v);
    int   i;
    logic got;
    i = v.inst;
    wait_idle(i);
    push_word(i, v.data);
    tick();
    for (int b = 0; b < v.nbits; b++) begin
      got = v.bits[b];
      for (int c = 0; c < CDIV[i]; c++) begin
        if (xmit[i] !== v.bits[b]) got = xmit[i];
        tick();
      end
      check($sformatf("frame_%0h_bit%0d", v.data, b), i, got, v.bits[b]);
    end
    check("frame_end_busy", i, busy[i], 1'b0);
    check("frame_end_line", i, xmit[i], 1'b1);
  endtask

  initial begin
    vec_t vecs [6];
    vec_t v3c;
    int   nxt, acc6, run, rate;
    logic [7:0] byte_v;
    logic seen;

    vecs[0] = '{0, 9'h055, 10, 16'b1010101010};
    vecs[1] = '{0, 9'h0A3, 10, 16'b1101000110};
    vecs[2] = '{1, 9'h007, 12, 16'b111000001110};
    vecs[3] = '{1, 9'h081, 12, 16'b110100000010};
    vecs[4] = '{2, 9'h000, 12, 16'b110000000000};
    vecs[5] = '{2, 9'h1FF, 12, 16'b101111111110};
    v3c     = '{0, 9'h03C, 10, 16'b1001111000};

    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = '0;
    end
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      check("reset_xmit", i, xmit[i], 1'b1);
      check("reset_busy", i, busy[i], 1'b0);
      check("reset_count", i, cnt[i], 0);
      check("reset_ready", i, tx_ready[i], 1'b1);
    end
    rst_n = 1'b1;
    tick();

    foreach (vecs[r]) run_vec(vecs[r]);

    // Six words offered back-to-back from reset into the 4-deep FIFO of inst0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 9'h0A1;
    nxt  = 0;
    acc6 = -1;
    trace.delete();
    for (int cyc = 1; cyc <= 242; cyc++) begin
      tick();
      if (tx_valid[0] && m_acc[0]) begin
        if (nxt == 5) acc6 = cyc;
        nxt++;
        if (nxt < 6) tx_data[0] = 9'h0A1 + 9'(nxt);
        else tx_valid[0] = 1'b0;
      end
      if (cyc == 5) begin
        check("b2b_full_count", 0, cnt[0], 4);
        check("b2b_full_ready", 0, tx_ready[0], 1'b0);
      end
      if (cyc >= 2) trace.push_back(xmit[0]);
    end
    tx_valid[0] = 1'b0;
    check("b2b_a6_accept_cycle", 0, 16'(acc6), 43);
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < 8; b++) byte_v[b] = trace[f*40 + (1 + b)*4 + 2];
      check($sformatf("b2b_byte%0d", f), 0, byte_v, 8'hA1 + 8'(f));
      check($sformatf("b2b_join%0d", f), 0,
            {(f == 0) ? 1'b1 : trace[f*40 - 1], trace[f*40]}, 2'b10);
    end
    check("b2b_done_busy", 0, busy[0], 1'b0);

    // Two stop bits on inst1: parity 0 then 8 high cycles before the next start.
    wait_idle(1);
    tx_valid[1] = 1'b1;
    tx_data[1]  = 9'h081;
    tick();
    tx_data[1]  = 9'h000;
    tick();
    tx_valid[1] = 1'b0;
    capture(1, 60);
    check("two_stop_parity", 1, trace[38], 1'b0);
    run = 0;
    while (40 + run < 60 && trace[40 + run] == 1'b1) run++;
    check("two_stop_high_run", 1, 16'(run), 8);

    // Reset during data bit 3 of the first of two queued frames on inst0.
    wait_idle(0);
    tx_valid[0] = 1'b1;
    tx_data[0]  = 9'h0FF;
    tick();
    tx_data[0]  = 9'h000;
    tick();
    tx_valid[0] = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_xmit", 0, xmit[0], 1'b1);
    check("midreset_count", 0, cnt[0], 0);
    check("midreset_busy", 0, busy[0], 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (xmit[0] !== 1'b1 || busy[0] !== 1'b0) seen = 1'b1;
      tick();
    end
    check("midreset_quiet", 0, seen, 1'b0);
    run_vec(v3c);

    // Randomised traffic on all instances, with rare one-cycle resets.
    for (int cyc = 0; cyc < 4500; cyc++) begin
      rate = (cyc < 1500) ? 8 : (cyc < 3000) ? 40 : 95;
      for (int i = 0; i < N; i++) begin
        tx_valid[i] = ($urandom_range(0, 99) < rate);
        tx_data[i]  = 9'($urandom_range(0, 511));
      end
      rst_n = ($urandom_range(0, 1499) != 0);
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) tx_valid[i] = 1'b0;
    for (int i = 0; i < N; i++) wait_idle(i);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
